npu_gemm_engine: RTL and testbench
==================================

Name: npu_gemm_engine

Overview:
- Parametrised NxN output-stationary systolic matrix-multiply engine computing C = A x B.
- Includes on-chip operand memories for A and B, a skewed edge feeder, the PE mesh, a control FSM, and a result read port.
- Replaces the fixed 3x3 feeder-plus-array pair with a start/busy/done handshake and host load/read access.

Parameters:
N, 3, array dimension and matrix size (legal 2..8)
DW, 8, operand element width
AW, 32, accumulator/result width (>= 2*DW required)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
ld_en  input  1  operand write strobe
ld_sel  input  1  0 = write A, 1 = write B
ld_addr  input  $clog2(N*N)  row-major element index (r*N+c)
ld_data  input  DW  operand element
start  input  1  begin multiply (sampled in IDLE only)
busy  output  1  high from cycle after start accepted through DONE
done  output  1  one-cycle pulse, results valid
rd_addr  input  $clog2(N*N)  result index r*N+c
rd_data  output  AW  registered C[rd_addr], 1-cycle latency

Behaviour:
- Reset: busy=0, done=0, rd_data=0, FSM=IDLE, all accumulators, A/B memories and edge registers cleared to 0. Reset mid-operation aborts immediately; no done pulse.
- FSM states: IDLE -> CLEAR -> FEED -> DONE -> IDLE.
- IDLE: start=1 -> CLEAR. ld_en writes A/B here only.
- CLEAR (1 cycle): zero all N*N accumulators, t=0.
- FEED: runs t = 0..3N-2 (3N-1 cycles), then -> DONE.
- DONE (1 cycle): done=1, busy=0 next cycle, -> IDLE.
- Timing: start sampled at cycle S gives done high at cycle S+3N+1 (S+10 for N=3).
- Edge injection at step t:
  - row r edge reg = A[r][t-r] if 0 <= t-r < N, else 0;
  - column c edge reg = B[t-c][c] if 0 <= t-c < N, else 0.
- PE(r,c) each FEED cycle: acc += a_in*b_in; registers a_in to PE(r,c+1) and b_in to PE(r+1,c). The last MAC lands at PE(N-1,N-1) by the final FEED cycle.
- Arithmetic: product is 2*DW bits, zero-extended to AW; accumulation wraps modulo 2^AW with no saturation and no overflow flag.
- Handshake rules:
  - start while busy is ignored.
  - ld_en while busy is ignored; operands stay frozen for the whole run.
  - start and ld_en in the same IDLE cycle: the write lands first, so the run uses the new value.
- Results persist after DONE until the next CLEAR.
- Reading during busy returns live partial sums (undefined for use).
- rd_addr >= N*N returns 0; ld_addr >= N*N is dropped.

Optional Feature:
- NPU_SIGNED_EN defined: operands are two's complement, products are sign-extended to AW, and rd_data is a signed two's-complement value.
- Undefined: unsigned operands, zero-extended products.
- Timing and control are identical in both builds.

Test Plan:
- N=3, A=B=[1..9] row-major, start -> done exactly 10 cycles after start; C = 30,36,42 / 66,81,96 / 102,126,150; busy high cycles S+1..S+10.
- N=4, A=identity, B=[1..16] -> C equals B; done at S+13; second start without reload reproduces the same result (CLEAR works).
- DW=8, AW=16, N=3, all A=B=255 -> every C = 64003 (195075 mod 65536).
- Mid-run: pulse start again and ld_en writing A[0]=99 at S+4 -> both ignored; C matches the first test; single done pulse.
- rst asserted at S+5 -> next cycle busy=0, done never pulses, rd_data of any address = 0; new load+start then runs cleanly.
- NPU_SIGNED_EN, N=3: A all 0xFF, B all 2 -> every C = -6 (0xFFFFFFFA). Without the macro, the same stimulus gives every C = 1530.

Source files
------------

// File: rtl/npu_gemm_engine.sv
// NxN output-stationary systolic GEMM engine (C = A x B) with operand RAMs, skewed feeder and result port.
// Define NPU_SIGNED_EN for two's-complement operands and sign-extended products.
module npu_gemm_engine #(
   parameter int unsigned N  = 3,
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ld_en,
   input  logic                     ld_sel,
   input  logic [$clog2(N*N)-1:0]   ld_addr,
   input  logic [DW-1:0]            ld_data,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic [$clog2(N*N)-1:0]   rd_addr,
   output logic [AW-1:0]            rd_data
);

   localparam int unsigned NN    = N * N;
   localparam int unsigned IW    = $clog2(NN);
   localparam int unsigned TW    = $clog2(3 * N);
   localparam int unsigned TLAST = 3 * N - 2;

   typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

   state_t          state;
   logic [TW-1:0]   t;
   logic [DW-1:0]   mem_a [NN];
   logic [DW-1:0]   mem_b [NN];
   logic [DW-1:0]   a_reg [NN];
   logic [DW-1:0]   b_reg [NN];
   logic [AW-1:0]   acc   [NN];

   function automatic logic [IW-1:0] idx(input int unsigned r, input int unsigned c);
      return IW'(r * N + c);
   endfunction

   function automatic logic [AW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef NPU_SIGNED_EN
      return {{(AW-DW){a[DW-1]}}, a} * {{(AW-DW){b[DW-1]}}, b};
`else
      return {{(AW-DW){1'b0}}, a} * {{(AW-DW){1'b0}}, b};
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NN; i++) begin
            mem_a[i] <= '0;
            mem_b[i] <= '0;
         end
      end else if (state == IDLE && ld_en && 32'(ld_addr) < NN) begin
         if (ld_sel)
            mem_b[ld_addr] <= ld_data;
         else
            mem_a[ld_addr] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         t     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               state <= FEED;
               t     <= '0;
            end
            FEED: begin
               if (32'(t) == TLAST) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  t <= t + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // a_reg/b_reg hold each PE's operand inputs; column 0 / row 0 entries are the skewed edge registers.
   always_ff @(posedge clk) begin
      if (rst || state == CLEAR) begin
         for (int unsigned i = 0; i < NN; i++) begin
            acc[i]   <= '0;
            a_reg[i] <= '0;
            b_reg[i] <= '0;
         end
      end else if (state == FEED) begin
         for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
               acc[idx(r, c)] <= acc[idx(r, c)] + prod(a_reg[idx(r, c)], b_reg[idx(r, c)]);
               if (c > 0)
                  a_reg[idx(r, c)] <= a_reg[idx(r, c - 1)];
               if (r > 0)
                  b_reg[idx(r, c)] <= b_reg[idx(r - 1, c)];
            end
         end
         for (int unsigned i = 0; i < N; i++) begin
            if (32'(t) >= i && 32'(t) - i < N) begin
               a_reg[idx(i, 0)] <= mem_a[idx(i, 32'(t) - i)];
               b_reg[idx(0, i)] <= mem_b[idx(32'(t) - i, i)];
            end else begin
               a_reg[idx(i, 0)] <= '0;
               b_reg[idx(0, i)] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else if (32'(rd_addr) < NN)
         rd_data <= acc[rd_addr];
      else
         rd_data <= '0;
   end

endmodule

// File: tb/tb_npu_gemm_engine.sv
// Directed bench for npu_gemm_engine: N=3/AW=32, N=4/AW=32 and N=3/AW=16 instances (honours NPU_SIGNED_EN).
module tb_npu_gemm_engine;

   logic        clk = 1'b0;
   logic        rst, ld_en, ld_en4, ld_sel, start, start4;
   logic [3:0]  ld_addr, rd_addr;
   logic [7:0]  ld_data;
   logic        busy3, done3, busy4, done4, busy16, done16;
   logic [31:0] rd3, rd4;
   logic [15:0] rd16;
   int          checks = 0;
   int          failures = 0;

`ifdef NPU_SIGNED_EN
   localparam logic [31:0] EXP_FF  = 32'd3;
   localparam logic [31:0] EXP_MIX = 32'hFFFF_FFFA;
`else
   localparam logic [31:0] EXP_FF  = 32'd195075;
   localparam logic [31:0] EXP_MIX = 32'd1530;
`endif

   int unsigned c1 [9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

   always #5 clk = ~clk;

   npu_gemm_engine #(.N(3), .DW(8), .AW(32)) u3 (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start), .busy(busy3), .done(done3), .rd_addr(rd_addr), .rd_data(rd3));

   npu_gemm_engine #(.N(4), .DW(8), .AW(32)) u4 (
      .clk(clk), .rst(rst), .ld_en(ld_en4), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start4), .busy(busy4), .done(done4), .rd_addr(rd_addr), .rd_data(rd4));

   npu_gemm_engine #(.N(3), .DW(8), .AW(16)) u16 (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start), .busy(busy16), .done(done16), .rd_addr(rd_addr), .rd_data(rd16));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic load(input bit g4, input bit sel, input int unsigned addr, input int unsigned data);
      if (g4) ld_en4 = 1'b1; else ld_en = 1'b1;
      ld_sel  = sel;
      ld_addr = 4'(addr);
      ld_data = 8'(data);
      tick;
      ld_en  = 1'b0;
      ld_en4 = 1'b0;
   endtask

   task automatic rd(input bit g4, input int unsigned addr, input logic [31:0] exp);
      rd_addr = 4'(addr);
      tick;
      if (g4) begin
         chk("rd4", rd4, exp);
      end else begin
         chk("rd3", rd3, exp);
         chk("rd16", 32'(rd16), exp & 32'h0000_FFFF);
      end
   endtask

   // mode 0: plain run; 1: start+write pulsed at S+4; 2: B[8]=2 written in the start cycle
   task automatic run(input bit g4, input int unsigned mode);
      int unsigned n = g4 ? 4 : 3;
      if (g4) start4 = 1'b1; else start = 1'b1;
      if (mode == 2) begin
         ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 4'd8; ld_data = 8'd2;
      end
      for (int unsigned k = 1; k <= 3 * n + 2; k++) begin
         tick;
         if (k == 1) begin start = 1'b0; start4 = 1'b0; ld_en = 1'b0; end
         if (g4) begin
            chk("busy4", 32'(busy4), 32'(k <= 3 * n + 1));
            chk("done4", 32'(done4), 32'(k == 3 * n + 1));
         end else begin
            chk("busy3", 32'(busy3), 32'(k <= 3 * n + 1));
            chk("done3", 32'(done3), 32'(k == 3 * n + 1));
            chk("done16", 32'(done16), 32'(k == 3 * n + 1));
         end
         if (mode == 1 && k == 4) begin
            start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 8'd99;
         end
         if (mode == 1 && k == 5) begin start = 1'b0; ld_en = 1'b0; end
      end
   endtask

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_en4 = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
      start = 1'b0; start4 = 1'b0; rd_addr = '0;
      tick;
      tick;
      chk("rst_busy3", 32'(busy3), 32'd0);
      chk("rst_done3", 32'(done3), 32'd0);
      chk("rst_rd3", rd3, 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_rd4", rd4, 32'd0);
      rst = 1'b0;

      // A = B = 1..9
      for (int unsigned i = 0; i < 9; i++) begin
         load(1'b0, 1'b0, i, i + 1);
         load(1'b0, 1'b1, i, i + 1);
      end
      run(1'b0, 0);
      for (int unsigned i = 0; i < 9; i++) rd(1'b0, i, c1[i]);
      rd(1'b0, 12, 32'd0);

      // N=4 identity x [1..16], then rerun without reload
      for (int unsigned i = 0; i < 16; i++) begin
         load(1'b1, 1'b0, i, (i % 5 == 0) ? 1 : 0);
         load(1'b1, 1'b1, i, i + 1);
      end
      run(1'b1, 0);
      for (int unsigned i = 0; i < 16; i++) rd(1'b1, i, i + 1);
      run(1'b1, 0);
      for (int unsigned i = 0; i < 16; i += 3) rd(1'b1, i, i + 1);

      // start and A[0]=99 pulsed mid-run are both ignored
      run(1'b0, 1);
      for (int unsigned i = 0; i < 9; i++) rd(1'b0, i, c1[i]);

      // reset at S+5 aborts the run and clears everything
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int unsigned k = 2; k <= 5; k++) tick;
      rst = 1'b1;
      tick;
      chk("abort_busy3", 32'(busy3), 32'd0);
      chk("abort_done3", 32'(done3), 32'd0);
      rst = 1'b0;
      for (int unsigned k = 0; k < 15; k++) begin
         tick;
         chk("abort_nodone", 32'(done3 | done16), 32'd0);
      end
      for (int unsigned i = 0; i < 9; i++) rd(1'b0, i, 32'd0);
      for (int unsigned i = 0; i < 9; i++) begin
         load(1'b0, 1'b0, i, i + 1);
         load(1'b0, 1'b1, i, i + 1);
      end
      run(1'b0, 0);
      for (int unsigned i = 0; i < 9; i++) rd(1'b0, i, c1[i]);

      // all operands 255: wraps in the 16-bit accumulator
      for (int unsigned i = 0; i < 9; i++) begin
         load(1'b0, 1'b0, i, 255);
         load(1'b0, 1'b1, i, 255);
      end
      run(1'b0, 0);
      for (int unsigned i = 0; i < 9; i++) rd(1'b0, i, EXP_FF);

      // A = 0xFF, B = 2; last B write coincides with start and must be used
      for (int unsigned i = 0; i < 8; i++) load(1'b0, 1'b1, i, 2);
      run(1'b0, 2);
      for (int unsigned i = 0; i < 9; i++) rd(1'b0, i, EXP_MIX);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
